// File: rtl/sodor5_rtype_wb_checker_if.sv
// Bundles the checker's shadow-load, issue, writeback and status signals.
// The master side is the harness, and the slave side is the checker.
interface sodor5_rtype_wb_checker_if #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = 16
);
    logic                 init_we;
    logic [4:0]           init_addr;
    logic [WORD_SIZE-1:0] init_data;
    logic                 run;
    logic                 instr_valid;
    logic [31:0]          instr;
    logic                 wb_valid;
    logic [4:0]           wb_addr;
    logic [WORD_SIZE-1:0] wb_data;
    logic [CNT_W-1:0]     match_count;
    logic [CNT_W-1:0]     mismatch_count;
    logic                 err_mismatch;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 busy;

    modport master (
        output init_we, init_addr, init_data, run, instr_valid, instr,
               wb_valid, wb_addr, wb_data,
        input  match_count, mismatch_count, err_mismatch, err_overflow,
               err_underflow, busy
    );

    modport slave (
        input  init_we, init_addr, init_data, run, instr_valid, instr,
               wb_valid, wb_addr, wb_data,
        output match_count, mismatch_count, err_mismatch, err_overflow,
               err_underflow, busy
    );
endinterface

// File: rtl/sodor5_rtype_wb_checker.sv
// In-order R-type writeback scoreboard: shadow regfile, expected-result FIFO, sticky error flags.
// Optional SODOR5_CHK_HALT_ON_FAIL_EN freezes the checker in a HALT state after the first error.
module sodor5_rtype_wb_checker #(
    parameter int NUM_REGS  = 32,
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    sodor5_rtype_wb_checker_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN
`ifdef SODOR5_CHK_HALT_ON_FAIL_EN
        , ST_HALT
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [CNT_W-1:0]     match_q, match_d, mismatch_q, mismatch_d;
    logic                 err_mm_q, err_mm_d, err_of_q, err_of_d, err_uf_q, err_uf_d;

    logic [WORD_SIZE-1:0] shadow_q [NUM_REGS];

    // Instruction fields
    logic [6:0]           opcode, funct7;
    logic [2:0]           funct3;
    logic [4:0]           rd, rs1, rs2;
    logic [WORD_SIZE-1:0] rs1_val, rs2_val, alu_res;
    logic [4:0]           shamt;
    logic                 is_rtype;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    assign rs1_val = (rs1 == 5'd0) ? '0 : shadow_q[rs1[AW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : shadow_q[rs2[AW-1:0]];
    assign shamt   = rs2_val[4:0];

    assign is_rtype = (opcode == 7'b0110011) &&
                      ((funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'd0: alu_res = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
            3'd1: alu_res = rs1_val << shamt;
            3'd2: alu_res = {{(WORD_SIZE-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
            3'd3: alu_res = {{(WORD_SIZE-1){1'b0}}, (rs1_val < rs2_val)};
            3'd4: alu_res = rs1_val ^ rs2_val;
            3'd5: alu_res = funct7[5] ? WORD_SIZE'($signed(rs1_val) >>> shamt)
                                      : (rs1_val >> shamt);
            3'd6: alu_res = rs1_val | rs2_val;
            default: alu_res = rs1_val & rs2_val;
        endcase
    end

    // FIFO storage: one register pair per entry, read through a packed mux
    logic [DEPTH-1:0][4:0]           fifo_rd;
    logic [DEPTH-1:0][WORD_SIZE-1:0] fifo_data;
    logic push_req, pop_req, push_ok, pop_ok;
    logic fifo_empty, fifo_full, head_eq;
    logic match_evt, mismatch_evt, overflow_evt, underflow_evt;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
            logic [4:0]           rd_q;
            logic [WORD_SIZE-1:0] data_q;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == PW'(gi))) begin
                    rd_q   <= rd;
                    data_q <= alu_res;
                end
            end
            assign fifo_rd[gi]   = rd_q;
            assign fifo_data[gi] = data_q;
        end
    endgenerate

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(DEPTH));

    assign push_req = (state_q == ST_RUN) && bus.instr_valid && is_rtype && (rd != 5'd0);
    assign pop_req  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                      bus.wb_valid && (bus.wb_addr != 5'd0);

    // A push into an empty FIFO cannot satisfy a same-cycle pop
    assign pop_ok        = pop_req && !fifo_empty;
    assign underflow_evt = pop_req && fifo_empty;
    assign push_ok       = push_req && (!fifo_full || pop_ok);
    assign overflow_evt  = push_req && fifo_full && !pop_ok;

    assign head_eq      = (fifo_rd[rd_ptr_q] == bus.wb_addr) &&
                          (fifo_data[rd_ptr_q] == bus.wb_data);
    assign match_evt    = pop_ok && head_eq;
    assign mismatch_evt = pop_ok && !head_eq;

    // Shadow regfile is deliberately left out of reset; x0 is never written
    always_ff @(posedge clk) begin
        if ((state_q == ST_INIT) && bus.init_we && (bus.init_addr != 5'd0))
            shadow_q[bus.init_addr[AW-1:0]] <= bus.init_data;
        else if (push_req)
            shadow_q[rd[AW-1:0]] <= alu_res;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop_ok);
        count_d    = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        match_d    = (match_evt && (match_q != '1)) ? match_q + 1'b1 : match_q;
        mismatch_d = (mismatch_evt && (mismatch_q != '1)) ? mismatch_q + 1'b1 : mismatch_q;
        err_mm_d   = err_mm_q | mismatch_evt;
        err_of_d   = err_of_q | overflow_evt;
        err_uf_d   = err_uf_q | underflow_evt;

        case (state_q)
            ST_INIT:  if (bus.run) state_d = ST_RUN;
            ST_RUN:   if (!bus.run) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_INIT;
            default:  state_d = state_q;
        endcase

`ifdef SODOR5_CHK_HALT_ON_FAIL_EN
        if (mismatch_evt || overflow_evt || underflow_evt)
            state_d = ST_HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            err_mm_q   <= 1'b0;
            err_of_q   <= 1'b0;
            err_uf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            err_mm_q   <= err_mm_d;
            err_of_q   <= err_of_d;
            err_uf_q   <= err_uf_d;
        end
    end

    assign bus.match_count    = match_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.err_mismatch   = err_mm_q;
    assign bus.err_overflow   = err_of_q;
    assign bus.err_underflow  = err_uf_q;
    assign bus.busy           = !fifo_empty;
endmodule

// File: tb/tb_sodor5_rtype_wb_checker.sv
// Directed bench for sodor5_rtype_wb_checker with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sodor5_rtype_wb_checker;
    localparam logic [31:0] I_ADD_X3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB_X4   = 32'h40208233; // sub  x4,x1,x2
    localparam logic [31:0] I_SRA_X5   = 32'h4020D2B3; // sra  x5,x1,x2
    localparam logic [31:0] I_SLTU_X6  = 32'h0022B333; // sltu x6,x5,x2
    localparam logic [31:0] I_NOP      = 32'h00000013;
    localparam logic [31:0] I_BAD_F7   = 32'h402091B3; // funct7=0x20 with sll
    localparam logic [31:0] I_ADD_X0   = 32'h00208033; // add  x0,x1,x2

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    sodor5_rtype_wb_checker_if #(.WORD_SIZE(32), .CNT_W(16)) bus ();

    sodor5_rtype_wb_checker #(
        .NUM_REGS(32), .WORD_SIZE(32), .DEPTH(8), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_status(input string tag, input int m, input int mm,
                                input bit e_mm, input bit e_of, input bit e_uf, input bit bsy);
        check({tag, ".match"},    32'(bus.match_count),    32'(m));
        check({tag, ".mismatch"}, 32'(bus.mismatch_count), 32'(mm));
        check({tag, ".err_mm"},   32'(bus.err_mismatch),   32'(e_mm));
        check({tag, ".err_of"},   32'(bus.err_overflow),   32'(e_of));
        check({tag, ".err_uf"},   32'(bus.err_underflow),  32'(e_uf));
        check({tag, ".busy"},     32'(bus.busy),           32'(bsy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset");
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        bus.init_we   = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        tick();
        bus.init_we   = 1'b0;
        $display("load  x%0d = 0x%08h", a, d);
    endtask

    task automatic issue(input logic [31:0] w);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        tick();
        bus.instr_valid = 1'b0;
        $display("issue 0x%08h", w);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        tick();
        bus.wb_valid = 1'b0;
        $display("wb    x%0d = 0x%08h", a, d);
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        bus.init_we     = 1'b0;
        bus.init_addr   = '0;
        bus.init_data   = '0;
        bus.run         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        tick();
        tick();
        reset = 1'b0;
        check_status("rst", 0, 0, 0, 0, 0, 0);

        // ADD: 5 + 3 = 8
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        start_run();
        issue(I_ADD_X3);
        check("add.busy", 32'(bus.busy), 32'd1);
        wb(5'd3, 32'd8);
        check_status("add", 1, 0, 0, 0, 0, 0);

        // SUB: expected 2, core reports 3
        bus.run = 1'b0;
        do_reset();
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        start_run();
        issue(I_SUB_X4);
        wb(5'd4, 32'd3);
        check_status("sub", 0, 1, 1, 0, 0, 0);
        issue(I_ADD_X3);
        wb(5'd3, 32'd8);
`ifdef SODOR5_CHK_HALT_ON_FAIL_EN
        check("sub.halt_match", 32'(bus.match_count), 32'd0);
`else
        check("sub.cont_match", 32'(bus.match_count), 32'd1);
`endif

        // Ignored words, then SRA feeding SLTU back to back, drained with run low
        bus.run = 1'b0;
        do_reset();
        load(5'd1, 32'h80000000);
        load(5'd2, 32'd4);
        start_run();
        issue(I_NOP);
        issue(I_BAD_F7);
        issue(I_ADD_X0);
        check("ignored.busy", 32'(bus.busy), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr       = I_SRA_X5;
        tick();
        $display("issue 0x%08h", I_SRA_X5);
        bus.instr       = I_SLTU_X6;
        tick();
        $display("issue 0x%08h", I_SLTU_X6);
        bus.instr_valid = 1'b0;
        bus.run         = 1'b0;
        check("dep.busy", 32'(bus.busy), 32'd1);
        wb(5'd5, 32'hF8000000);
        wb(5'd6, 32'd0);
        check_status("dep", 2, 0, 0, 0, 0, 0);
        tick();

        // Overflow on the 9th push into an 8-entry FIFO
        do_reset();
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        start_run();
        for (int i = 0; i < 8; i++) issue(I_ADD_X3);
        check("ovf8.err_of", 32'(bus.err_overflow), 32'd0);
        check("ovf8.busy",   32'(bus.busy),         32'd1);
        issue(I_ADD_X3);
        check("ovf9.err_of", 32'(bus.err_overflow), 32'd1);
        for (int i = 0; i < 8; i++) wb(5'd3, 32'd8);
`ifdef SODOR5_CHK_HALT_ON_FAIL_EN
        check_status("ovf_drain", 0, 0, 0, 1, 0, 1);
`else
        check_status("ovf_drain", 8, 0, 0, 1, 0, 0);
`endif

        // Underflow: x0 writeback is harmless, x7 writeback is not
        bus.run = 1'b0;
        do_reset();
        start_run();
        wb(5'd0, 32'd1);
        check("udf0.err_uf", 32'(bus.err_underflow), 32'd0);
        wb(5'd7, 32'd1);
        check_status("udf7", 0, 0, 0, 0, 1, 0);

        // Reset in the middle of a run
        bus.run = 1'b0;
        do_reset();
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        start_run();
        for (int i = 0; i < 3; i++) issue(I_ADD_X3);
        wb(5'd3, 32'd8);
        check_status("midrst.pre", 1, 0, 0, 0, 0, 1);
        bus.run = 1'b0;
        do_reset();
        check_status("midrst.post", 0, 0, 0, 0, 0, 0);
        issue(I_ADD_X3);
        check("midrst.init_busy", 32'(bus.busy), 32'd0);
        wb(5'd3, 32'd8);
        check("midrst.init_uf", 32'(bus.err_underflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
